// File: rtl/vga_frame_buffer_writer_pkg.sv
// Shared widths, reset word, FSM encoding and VSync polarity helper for the VGA frame buffer writer.
package vga_frame_buffer_writer_pkg;

  localparam int         DEF_DW         = 8;
  localparam int         DEF_AW         = 4;
  localparam logic [7:0] DEF_RESET_WORD = 8'h00;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    WAIT_VS = 2'd1,
    COPY    = 2'd2
  } fb_state_e;

  function automatic logic vs_is_active(input logic vs, input bit active_low);
    return active_low ? ~vs : vs;
  endfunction

endpackage

// File: rtl/vga_fb_bank.sv
// One display bank: 2**AW x DW registers, one synchronous write port, async reset fill.
// Port a serves the display, port b feeds the post-swap copy; both are combinational.
module vga_fb_bank
  import vga_frame_buffer_writer_pkg::*;
#(
  parameter int             DW         = DEF_DW,
  parameter int             AW         = DEF_AW,
  parameter logic [DW-1:0]  RESET_WORD = DW'(DEF_RESET_WORD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [(2**AW)-1:0][DW-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= {(2**AW){RESET_WORD}};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/vga_frame_buffer_writer.sv
// Double-buffered 16x8 display memory: writes go to the back bank, banks swap at VSync start, then front is copied to back.
// Optional swap counter / overrun flag under VGA_FRAME_BUFFER_SWAPCNT_EN.
module vga_frame_buffer_writer
  import vga_frame_buffer_writer_pkg::*;
#(
  parameter int            DW            = DEF_DW,
  parameter int            AW            = DEF_AW,
  parameter bit            VS_ACTIVE_LOW = 1'b1,
  parameter logic [DW-1:0] RESET_WORD    = DW'(DEF_RESET_WORD)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          WrValid,
  output logic          WrReady,
  input  logic [AW-1:0] WrAddr,
  input  logic [DW-1:0] WrData,
  input  logic          Commit,
  input  logic          VSync,
  input  logic [AW-1:0] MemAddrIN,
  output logic [DW-1:0] MemDataOut,
  output logic          SwapPending,
  output logic          Busy
`ifdef VGA_FRAME_BUFFER_SWAPCNT_EN
  ,
  output logic [7:0]    SwapCount,
  output logic          Overrun
`endif
);

  localparam logic VS_IDLE = VS_ACTIVE_LOW;

  fb_state_e     state, state_nxt;
  logic          front_sel;
  logic [AW-1:0] cp_idx;
  logic          vs_q;
  logic          vs_start;

  logic          back_we;
  logic [AW-1:0] back_waddr;
  logic [DW-1:0] back_wdata;
  logic          take_commit;
  logic          take_swap;

  logic [DW-1:0] rd0_a, rd0_b, rd1_a, rd1_b;
  logic [DW-1:0] cp_data;

  assign vs_start = (vs_q == VS_IDLE) & vs_is_active(VSync, VS_ACTIVE_LOW);

  // front_sel = 1 means bank 1 is displayed and bank 0 is the back bank
  vga_fb_bank #(.DW(DW), .AW(AW), .RESET_WORD(RESET_WORD)) u_bank0 (
    .clk     (CLK),
    .rst_n   (RESET),
    .we      (back_we & front_sel),
    .waddr   (back_waddr),
    .wdata   (back_wdata),
    .raddr_a (MemAddrIN),
    .rdata_a (rd0_a),
    .raddr_b (cp_idx),
    .rdata_b (rd0_b)
  );

  vga_fb_bank #(.DW(DW), .AW(AW), .RESET_WORD(RESET_WORD)) u_bank1 (
    .clk     (CLK),
    .rst_n   (RESET),
    .we      (back_we & ~front_sel),
    .waddr   (back_waddr),
    .wdata   (back_wdata),
    .raddr_a (MemAddrIN),
    .rdata_a (rd1_a),
    .raddr_b (cp_idx),
    .rdata_b (rd1_b)
  );

  assign MemDataOut = front_sel ? rd1_a : rd0_a;
  assign cp_data    = front_sel ? rd1_b : rd0_b;

  always_comb begin
    state_nxt   = state;
    WrReady     = 1'b0;
    Busy        = 1'b0;
    back_we     = 1'b0;
    back_waddr  = WrAddr;
    back_wdata  = WrData;
    take_commit = 1'b0;
    take_swap   = 1'b0;
    case (state)
      FILL: begin
        WrReady = 1'b1;
        back_we = WrValid;
        // a vs_start in this cycle is deliberately not looked at
        if (Commit) begin
          state_nxt   = WAIT_VS;
          take_commit = 1'b1;
        end
      end
      WAIT_VS: begin
        Busy = 1'b1;
        if (vs_start) begin
          state_nxt = COPY;
          take_swap = 1'b1;
        end
      end
      COPY: begin
        Busy       = 1'b1;
        back_we    = 1'b1;
        back_waddr = cp_idx;
        back_wdata = cp_data;
        if (cp_idx == {AW{1'b1}}) begin
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= FILL;
      front_sel   <= 1'b0;
      cp_idx      <= '0;
      vs_q        <= VS_IDLE;
      SwapPending <= 1'b0;
    end else begin
      state <= state_nxt;
      vs_q  <= VSync;
      if (take_commit) begin
        SwapPending <= 1'b1;
      end
      if (take_swap) begin
        front_sel   <= ~front_sel;
        SwapPending <= 1'b0;
        cp_idx      <= '0;
      end else if (state == COPY) begin
        cp_idx <= cp_idx + 1'b1;
      end
    end
  end

`ifdef VGA_FRAME_BUFFER_SWAPCNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      SwapCount <= 8'd0;
      Overrun   <= 1'b0;
    end else begin
      if (take_swap) begin
        SwapCount <= SwapCount + 8'd1;
      end
      if ((state == WAIT_VS) && Commit) begin
        Overrun <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_frame_buffer_writer.sv
// Randomised and directed bench for vga_frame_buffer_writer against a two-array display/batch model.
module tb_vga_frame_buffer_writer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       WrValid;
  logic       WrReady;
  logic [3:0] WrAddr;
  logic [7:0] WrData;
  logic       Commit;
  logic       VSync;
  logic [3:0] MemAddrIN;
  logic [7:0] MemDataOut;
  logic       SwapPending;
  logic       Busy;
`ifdef VGA_FRAME_BUFFER_SWAPCNT_EN
  logic [7:0] SwapCount;
  logic       Overrun;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: front_m is what is displayed, back_m is the batch being built.
  // After a swap plus copy, the back bank equals the new display, so a swap is front_m = back_m.
  logic [7:0] front_m [16];
  logic [7:0] back_m  [16];
  int         swaps_m;

  always #5 CLK = ~CLK;

  vga_frame_buffer_writer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WrValid     (WrValid),
    .WrReady     (WrReady),
    .WrAddr      (WrAddr),
    .WrData      (WrData),
    .Commit      (Commit),
    .VSync       (VSync),
    .MemAddrIN   (MemAddrIN),
    .MemDataOut  (MemDataOut),
    .SwapPending (SwapPending),
    .Busy        (Busy)
`ifdef VGA_FRAME_BUFFER_SWAPCNT_EN
    ,
    .SwapCount   (SwapCount),
    .Overrun     (Overrun)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    MemAddrIN = a;
    #1;
    d = MemDataOut;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      front_m[i] = 8'h00;
      back_m[i]  = 8'h00;
    end
    swaps_m = 0;
  endtask

  task automatic model_swap();
    for (int i = 0; i < 16; i++) front_m[i] = back_m[i];
    swaps_m++;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!WrReady && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    int n;
    WrValid = 1'b1;
    WrAddr  = a;
    WrData  = d;
    wait_ready(n);
    checks++;
    if (!WrReady) begin
      failures++;
      $display("FAIL write_accept addr=%0d: WrReady never rose within %0d cycles", a, n);
    end else begin
      step();
      back_m[a] = d;
    end
    WrValid = 1'b0;
  endtask

  task automatic do_commit();
    Commit = 1'b1;
    step();
    Commit = 1'b0;
  endtask

  task automatic do_swap();
    VSync = 1'b0;
    step();
    model_swap();
    step();
    VSync = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #3 RESET = 1'b0;
    #2;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), d);
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL reset_mem addr=%0d got=%h exp=00", i, d);
      end
    end
    checks++;
    if (WrReady !== 1'b1 || SwapPending !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got rdy=%b pend=%b busy=%b exp 1 0 0", WrReady, SwapPending, Busy);
    end
`ifdef VGA_FRAME_BUFFER_SWAPCNT_EN
    checks++;
    if (SwapCount !== 8'd0 || Overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt got cnt=%0d ovr=%b exp 0 0", SwapCount, Overrun);
    end
`endif
    step();
    RESET = 1'b1;
    step();
  endtask

  task automatic test_basic_swap();
    logic [7:0] d;
    int n;
    do_write(4'd3, 8'h41);
    do_write(4'd7, 8'h5A);
    do_commit();
    checks++;
    if (SwapPending !== 1'b1 || WrReady !== 1'b0 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL commit_flags got pend=%b rdy=%b busy=%b exp 1 0 1", SwapPending, WrReady, Busy);
    end
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), d);
      checks++;
      if (d !== front_m[i]) begin
        failures++;
        $display("FAIL pre_swap addr=%0d got=%h exp=%h", i, d, front_m[i]);
      end
    end
    step();
    MemAddrIN = 4'd3;
    VSync = 1'b0;
    step();
    model_swap();
    checks++;
    if (MemDataOut !== 8'h41 || SwapPending !== 1'b0) begin
      failures++;
      $display("FAIL swap_edge got data3=%h pend=%b exp 41 0", MemDataOut, SwapPending);
    end
    rd(4'd7, d);
    checks++;
    if (d !== 8'h5A) begin
      failures++;
      $display("FAIL swap_edge addr=7 got=%h exp=5a", d);
    end
    VSync = 1'b1;
    wait_ready(n);
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL copy_busy_cycles got=%0d exp=16", n);
    end
  endtask

  task automatic test_copy();
    logic [7:0] d;
    int n;
    do_write(4'd3, 8'h42);
    do_commit();
    do_swap();
    wait_ready(n);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), d);
      checks++;
      if (d !== front_m[i]) begin
        failures++;
        $display("FAIL copy_front addr=%0d got=%h exp=%h", i, d, front_m[i]);
      end
    end
    step();
  endtask

  task automatic test_hold_in_wait();
    logic [7:0] d;
    int n;
    do_commit();
    WrValid = 1'b1;
    WrAddr  = 4'd5;
    WrData  = 8'hFF;
    Commit  = 1'b1;
    step();
    Commit  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (WrReady !== 1'b0 || SwapPending !== 1'b1) begin
        failures++;
        $display("FAIL wait_hold cyc=%0d got rdy=%b pend=%b exp 0 1", k, WrReady, SwapPending);
      end
      step();
    end
`ifdef VGA_FRAME_BUFFER_SWAPCNT_EN
    checks++;
    if (Overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun got=%b exp=1", Overrun);
    end
`endif
    VSync = 1'b0;
    step();
    model_swap();
    VSync = 1'b1;
    wait_ready(n);
    step();
    back_m[5] = 8'hFF;
    WrValid = 1'b0;
    rd(4'd5, d);
    checks++;
    if (d !== front_m[5]) begin
      failures++;
      $display("FAIL held_write_hidden got=%h exp=%h", d, front_m[5]);
    end
    step();
    do_commit();
    do_swap();
    wait_ready(n);
    rd(4'd5, d);
    checks++;
    if (d !== 8'hFF) begin
      failures++;
      $display("FAIL held_write_visible got=%h exp=ff", d);
    end
    step();
  endtask

  task automatic test_commit_with_vs();
    logic [7:0] d;
    int n;
    do_write(4'd0, 8'h11);
    Commit = 1'b1;
    VSync  = 1'b0;
    MemAddrIN = 4'd0;
    step();
    Commit = 1'b0;
    step();
    step();
    checks++;
    if (SwapPending !== 1'b1 || MemDataOut !== front_m[0]) begin
      failures++;
      $display("FAIL same_cycle_no_swap got pend=%b data=%h exp 1 %h", SwapPending, MemDataOut, front_m[0]);
    end
    VSync = 1'b1;
    step();
    step();
    do_swap();
    wait_ready(n);
    rd(4'd0, d);
    checks++;
    if (d !== 8'h11) begin
      failures++;
      $display("FAIL next_vs_swap got=%h exp=11", d);
    end
    step();
  endtask

  task automatic test_reset_mid_copy();
    logic [7:0] d;
    int n;
    do_write(4'd9, 8'hC3);
    do_commit();
    VSync = 1'b0;
    step();
    VSync = 1'b1;
    for (int k = 0; k < 8; k++) step();
    RESET = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), d);
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL mid_copy_reset addr=%0d got=%h exp=00", i, d);
      end
    end
    checks++;
    if (WrReady !== 1'b1 || SwapPending !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_copy_flags got rdy=%b pend=%b busy=%b exp 1 0 0", WrReady, SwapPending, Busy);
    end
    step();
    RESET = 1'b1;
    step();
    for (int s = 0; s < 3; s++) begin
      do_commit();
      do_swap();
      wait_ready(n);
    end
    rd(4'd9, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_swaps addr=9 got=%h exp=00", d);
    end
`ifdef VGA_FRAME_BUFFER_SWAPCNT_EN
    checks++;
    if (SwapCount !== 8'd3) begin
      failures++;
      $display("FAIL swap_count got=%0d exp=3", SwapCount);
    end
`endif
    step();
  endtask

  task automatic test_random_batches();
    logic [7:0] d;
    logic [3:0] a;
    int n;
    for (int b = 0; b < 24; b++) begin
      n = $urandom_range(0, 6);
      for (int w = 0; w < n; w++) do_write(4'($urandom_range(0, 15)), 8'($urandom));
      for (int k = $urandom_range(0, 3); k > 0; k--) step();
      do_commit();
      for (int k = $urandom_range(0, 4); k > 0; k--) step();
      a = 4'($urandom_range(0, 15));
      rd(a, d);
      checks++;
      if (d !== front_m[a] || SwapPending !== 1'b1) begin
        failures++;
        $display("FAIL rand_wait b=%0d addr=%0d got=%h pend=%b exp=%h 1", b, a, d, SwapPending, front_m[a]);
      end
      step();
      do_swap();
      wait_ready(n);
      for (int i = 0; i < 16; i++) begin
        rd(4'(i), d);
        checks++;
        if (d !== front_m[i]) begin
          failures++;
          $display("FAIL rand_front b=%0d addr=%0d got=%h exp=%h", b, i, d, front_m[i]);
        end
      end
      step();
    end
`ifdef VGA_FRAME_BUFFER_SWAPCNT_EN
    checks++;
    if (SwapCount !== 8'(swaps_m)) begin
      failures++;
      $display("FAIL rand_swap_count got=%0d exp=%0d", SwapCount, swaps_m & 255);
    end
`endif
  endtask

  initial begin
    RESET     = 1'b1;
    WrValid   = 1'b0;
    WrAddr    = 4'd0;
    WrData    = 8'h00;
    Commit    = 1'b0;
    VSync     = 1'b1;
    MemAddrIN = 4'd0;
    model_reset();
    test_reset();
    test_basic_swap();
    test_copy();
    test_hold_in_wait();
    test_commit_with_vs();
    test_reset_mid_copy();
    test_random_batches();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
